// File: rtl/simon_sequence_checker.sv
// Simon Says sequence store, timed playback and step-by-step player input checker.
// Holds up to MAX_LEN symbols; replays them with on/gap timing, then checks inputs with a timeout.
module simon_sequence_checker #(
    parameter int unsigned DIR_W        = 2,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned PLAY_ON_CYC  = 25000000,
    parameter int unsigned PLAY_GAP_CYC = 12500000,
    parameter int unsigned TIMEOUT_CYC  = 250000000,
    localparam int unsigned CNT_W       = $clog2(MAX_LEN + 1),
    localparam int unsigned STEP_W      = $clog2(MAX_LEN)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push_valid,
    input  logic [DIR_W-1:0]  push_dir,
    output logic              push_ready,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DIR_W-1:0]  in_dir,
    output logic              play_valid,
    output logic [DIR_W-1:0]  play_dir,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic [STEP_W-1:0] step,
    output logic              hit,
    output logic              round_pass,
    output logic              round_fail,
    output logic              timed_out
);

    localparam int unsigned TMR_MAX_PG = (PLAY_ON_CYC > PLAY_GAP_CYC) ? PLAY_ON_CYC : PLAY_GAP_CYC;
    localparam int unsigned TMR_MAX    = (TMR_MAX_PG > TIMEOUT_CYC) ? TMR_MAX_PG : TIMEOUT_CYC;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StPlayOn,
        StPlayGap,
        StCheck
    } state_e;

    state_e            state_q;
    logic [TMR_W-1:0]  timer_q;
    logic [DIR_W-1:0]  mem [MAX_LEN];

    logic [CNT_W-1:0]  last_idx;
    logic [STEP_W-1:0] next_step;
    logic              at_last;
    logic              in_match;
    logic              push_accept;

    assign last_idx    = count - CNT_W'(1);
    assign next_step   = step + STEP_W'(1);
    assign at_last     = (CNT_W'(step) == last_idx);
    assign in_match    = (in_dir == mem[step]);
    assign busy        = (state_q != StIdle);
    assign push_ready  = (state_q == StIdle) && (count < CNT_W'(MAX_LEN));
    assign push_accept = push_valid && push_ready && !clear && !abort;

    // Symbol storage survives reset and clear; only count marks valid entries.
    always_ff @(posedge clock) begin
        if (push_accept) begin
            mem[count[STEP_W-1:0]] <= push_dir;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            count      <= '0;
            step       <= '0;
            play_valid <= 1'b0;
            play_dir   <= '0;
            hit        <= 1'b0;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            hit        <= 1'b0;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            if (abort) begin
                state_q    <= StIdle;
                timer_q    <= '0;
                step       <= '0;
                play_valid <= 1'b0;
                play_dir   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (clear) begin
                            count <= '0;
                        end else if (push_accept) begin
                            count <= count + CNT_W'(1);
                        end
                        // A simultaneous clear wins, so the start is dropped with it.
                        if (start && !clear && (count != '0)) begin
                            state_q    <= StPlayOn;
                            timer_q    <= '0;
                            step       <= '0;
                            timed_out  <= 1'b0;
                            play_valid <= 1'b1;
                            play_dir   <= mem[0];
                        end
                    end
                    StPlayOn: begin
                        if (timer_q == TMR_W'(PLAY_ON_CYC - 1)) begin
                            state_q    <= StPlayGap;
                            timer_q    <= '0;
                            play_valid <= 1'b0;
                            play_dir   <= '0;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    StPlayGap: begin
                        if (timer_q == TMR_W'(PLAY_GAP_CYC - 1)) begin
                            timer_q <= '0;
                            if (at_last) begin
                                state_q <= StCheck;
                                step    <= '0;
                            end else begin
                                state_q    <= StPlayOn;
                                step       <= next_step;
                                play_valid <= 1'b1;
                                play_dir   <= mem[next_step];
                            end
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    StCheck: begin
                        // An input on the expiry cycle is judged as an input, not a timeout.
                        if (in_valid) begin
                            timer_q <= '0;
                            if (in_match && !at_last) begin
                                hit  <= 1'b1;
                                step <= next_step;
                            end else begin
                                round_pass <= in_match;
                                round_fail <= !in_match;
                                state_q    <= StIdle;
                                step       <= '0;
                            end
                        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                            round_fail <= 1'b1;
                            timed_out  <= 1'b1;
                            state_q    <= StIdle;
                            timer_q    <= '0;
                            step       <= '0;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_sequence_checker.sv
// Scoreboarded bench: stimulus queues expected playback/result events, a monitor pops and compares.
module tb_simon_sequence_checker;

    localparam int DIR_W   = 2;
    localparam int MAX_LEN = 4;
    localparam int ON      = 3;
    localparam int GAP     = 2;
    localparam int TO      = 10;
    localparam int SYM     = ON + GAP;

    localparam int KPlay = 0;
    localparam int KHit  = 1;
    localparam int KPass = 2;
    localparam int KFail = 3;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             push_valid = 1'b0;
    logic [DIR_W-1:0] push_dir = '0;
    logic             push_ready;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [DIR_W-1:0] in_dir = '0;
    logic             play_valid;
    logic [DIR_W-1:0] play_dir;
    logic             busy;
    logic [2:0]       count;
    logic [1:0]       step;
    logic             hit;
    logic             round_pass;
    logic             round_fail;
    logic             timed_out;

    simon_sequence_checker #(
        .DIR_W        (DIR_W),
        .MAX_LEN      (MAX_LEN),
        .PLAY_ON_CYC  (ON),
        .PLAY_GAP_CYC (GAP),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .push_valid (push_valid),
        .push_dir   (push_dir),
        .push_ready (push_ready),
        .clear      (clear),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_dir     (in_dir),
        .play_valid (play_valid),
        .play_dir   (play_dir),
        .busy       (busy),
        .count      (count),
        .step       (step),
        .hit        (hit),
        .round_pass (round_pass),
        .round_fail (round_fail),
        .timed_out  (timed_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  seq[$];
    int  plan_act[$];
    int  plan_gap[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_ev(input int k, input int v, input int c);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic do_push(input int d);
        push_valid = 1'b1;
        push_dir   = 2'(d);
        chk("push_ready", int'(push_ready), int'(seq.size() < MAX_LEN));
        tick();
        push_valid = 1'b0;
        if (seq.size() < MAX_LEN) seq.push_back(d);
        chk("count after push", int'(count), seq.size());
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        seq.delete();
        chk("count after clear", int'(count), 0);
    endtask

    // Queues playback events with cycle below s+cut; returns the cycle CHECK is entered.
    task automatic do_start(input int cut, output int c_entry);
        int s;
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
        chk("busy after start", int'(busy), 1);
        chk("timed_out cleared by start", int'(timed_out), 0);
        foreach (seq[i]) begin
            for (int j = 0; j < ON; j++) begin
                if (i * SYM + j < cut) expect_ev(KPlay, seq[i], s + i * SYM + j);
            end
        end
        c_entry = s + seq.size() * SYM;
    endtask

    // plan_act: 0 correct, 1 wrong symbol, 2 let it time out; plan_gap: cycles since last input
    task automatic play_round(input int c_entry);
        int last;
        int t;
        last = c_entry;
        for (int i = 0; i < seq.size(); i++) begin
            if (plan_act[i] == 2) begin
                expect_ev(KFail, 1, last + TO);
                wait_until(last + TO + 1);
                return;
            end
            t = last + plan_gap[i];
            wait_until(t - 1);
            in_valid = 1'b1;
            in_dir   = (plan_act[i] == 1) ? 2'(seq[i] ^ int'($urandom_range(1, 3))) : 2'(seq[i]);
            tick();
            in_valid = 1'b0;
            if (plan_act[i] == 1) begin
                expect_ev(KFail, 0, t);
                tick();
                return;
            end
            if (i == seq.size() - 1) begin
                expect_ev(KPass, seq.size(), t);
                tick();
                return;
            end
            expect_ev(KHit, i + 1, t);
            last = t;
        end
    endtask

    int   m_n;
    int   m_kind;
    int   m_val;
    ev_t  m_e;

    always @(negedge clock) begin
        if (resetn) begin
            if (!play_valid) chk("play_dir blank", int'(play_dir), 0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed event cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            m_n = int'(play_valid) + int'(hit) + int'(round_pass) + int'(round_fail);
            if (m_n > 1) chk("single event per cycle", m_n, 1);
            if (m_n > 0) begin
                if (play_valid) begin
                    m_kind = KPlay;
                    m_val  = int'(play_dir);
                end else if (hit) begin
                    m_kind = KHit;
                    m_val  = int'(step);
                end else if (round_pass) begin
                    m_kind = KPass;
                    m_val  = int'(busy) * 8 + int'(count);
                end else begin
                    m_kind = KFail;
                    m_val  = int'(busy) * 2 + int'(timed_out);
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected event kind", m_kind, -1);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("event cycle", cyc, m_e.cyc);
                    chk("event kind", m_kind, m_e.kind);
                    chk("event value", m_val, m_e.val);
                end
            end
        end
    end

    initial begin
        int c;
        int n;

        repeat (3) tick();
        chk("reset count", int'(count), 0);
        chk("reset step", int'(step), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset play_valid", int'(play_valid), 0);
        chk("reset timed_out", int'(timed_out), 0);
        chk("reset pulses", int'(hit) + int'(round_pass) + int'(round_fail), 0);
        resetn = 1'b1;
        tick();
        chk("push_ready after reset", int'(push_ready), 1);

        // Correct round, including a gap right at the timeout boundary
        do_push(2);
        do_push(0);
        do_push(3);
        do_start(1000, c);
        plan_act = '{0, 0, 0};
        plan_gap = '{1, TO, 3};
        play_round(c);
        chk("count kept after pass", int'(count), 3);

        // Wrong second input
        do_start(1000, c);
        plan_act = '{0, 1, 0};
        plan_gap = '{2, 4, 1};
        play_round(c);
        chk("busy after fail", int'(busy), 0);

        // Timeout after one hit; timed_out is held until next start
        do_start(1000, c);
        plan_act = '{0, 2, 0};
        plan_gap = '{5, 1, 1};
        play_round(c);
        repeat (4) tick();
        chk("timed_out held", int'(timed_out), 1);

        // Timeout with no input at all pins the CHECK entry cycle
        do_start(1000, c);
        plan_act = '{2, 0, 0};
        plan_gap = '{1, 1, 1};
        play_round(c);

        // Overfill then replay the four kept symbols
        do_clear();
        for (int i = 0; i < 5; i++) do_push(int'($urandom_range(0, 3)));
        chk("count at full", int'(count), MAX_LEN);
        chk("push_ready at full", int'(push_ready), 0);
        do_start(1000, c);
        plan_act = '{0, 0, 0, 0};
        plan_gap = '{3, 1, 7, 2};
        play_round(c);

        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start with empty ignored", int'(busy), 0);
        tick();
        chk("still idle", int'(busy), 0);

        for (int r = 0; r < 25; r++) begin
            if (seq.size() == MAX_LEN || $urandom_range(0, 3) == 0) do_clear();
            n = int'($urandom_range(0, MAX_LEN - seq.size()));
            if (seq.size() + n == 0) n = 1;
            for (int i = 0; i < n; i++) do_push(int'($urandom_range(0, 3)));
            do_start(1000, c);
            plan_act.delete();
            plan_gap.delete();
            for (int i = 0; i < seq.size(); i++) begin
                n = int'($urandom_range(0, 9));
                plan_act.push_back(n == 0 ? 2 : (n == 1 ? 1 : 0));
                plan_gap.push_back(int'($urandom_range(1, TO)));
            end
            play_round(c);
        end

        // Abort in the middle of the first symbol
        if (seq.size() == 0) do_push(1);
        do_start(2, c);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort play_valid", int'(play_valid), 0);
        chk("abort step", int'(step), 0);
        chk("abort keeps count", int'(count), seq.size());
        repeat (20) tick();

        // Asynchronous reset during CHECK
        do_start(1000, c);
        wait_until(c + 3);
        resetn = 1'b0;
        #2;
        seq.delete();
        chk("reset mid-check busy", int'(busy), 0);
        chk("reset mid-check count", int'(count), 0);
        chk("reset mid-check pulses", int'(hit) + int'(round_pass) + int'(round_fail), 0);
        chk("reset mid-check play_valid", int'(play_valid), 0);
        tick();
        tick();
        resetn = 1'b1;
        repeat (20) tick();

        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_sequence_checker.md
# simon_sequence_checker

Parametrised sequence store, playback and comparison engine for the Simon Says game. It holds up to MAX_LEN directions appended by the sequence generator and replays them to the LED/display driver with programmable on/gap timing. It then checks the player's button inputs step by step against the stored sequence, with an inactivity timeout. It replaces the fixed four-stage arrow shift chain with a depth- and width-generic block.

## Interface
- DIR_W, 2, bits per direction symbol
- MAX_LEN, 16, maximum stored sequence length (≥2)
- PLAY_ON_CYC, 25000000, cycles each symbol is shown (≥1)
- PLAY_GAP_CYC, 12500000, blank cycles after each symbol (≥1)
- TIMEOUT_CYC, 250000000, maximum cycles between player inputs (≥1)
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- push_valid  in  1  append push_dir to the sequence
- push_dir  in  DIR_W  symbol to append
- push_ready  out  1  high when state is IDLE and count < MAX_LEN
- clear  in  1  empty the sequence (honoured only in IDLE)
- start  in  1  begin playback of the current sequence
- abort  in  1  return to IDLE from any state; sequence is kept
- in_valid  in  1  one-cycle player input strobe
- in_dir  in  DIR_W  player input symbol
- play_valid  out  1  symbol being shown
- play_dir  out  DIR_W  symbol shown; 0 when play_valid is low
- busy  out  1  state is not IDLE
- count  out  $clog2(MAX_LEN+1)  stored sequence length
- step  out  $clog2(MAX_LEN)  current playback/check index
- hit  out  1  one-cycle pulse: correct input, round not yet finished
- round_pass  out  1  one-cycle pulse: final symbol matched
- round_fail  out  1  one-cycle pulse: mismatch or timeout
- timed_out  out  1  qualifies round_fail; held until the next start or reset

## Operation
- Storage is an indexed register array mem[0..MAX_LEN-1]. Append writes mem[count] and increments count. Contents are not cleared by reset or by clear; only count is.
- States: IDLE, PLAY_ON, PLAY_GAP, CHECK.
- IDLE:
  - push accepted when push_valid && push_ready.
  - clear sets count=0. clear takes priority over push in the same cycle.
  - start with count==0 is ignored.
  - start with count>0 goes to PLAY_ON with step=0, timer=0, and clears timed_out.
- PLAY_ON: play_valid=1, play_dir=mem[step]. After PLAY_ON_CYC cycles, go to PLAY_GAP.
- PLAY_GAP: outputs blank. After PLAY_GAP_CYC cycles:
  - if step==count-1, go to CHECK with step=0 and timeout counter=0;
  - otherwise step+1 and go to PLAY_ON.
- CHECK: the timeout counter increments each cycle and resets to 0 on each in_valid.
  - in_valid && in_dir==mem[step] && step<count-1: hit, step+1.
  - in_valid && in_dir==mem[step] && step==count-1: round_pass, go to IDLE.
  - in_valid && mismatch: round_fail, go to IDLE.
  - No in_valid while the counter equals TIMEOUT_CYC-1: round_fail and timed_out=1, go to IDLE.
  - in_valid in the same cycle as timeout expiry is evaluated as an input; the timeout is not taken.
- in_valid outside CHECK is ignored. push, clear and start outside IDLE are ignored.
- abort has the highest priority. It forces IDLE, blanks play outputs and sets step=0. No pulse is generated.

## Timing
- All outputs are registered except push_ready and busy, which are decoded from state and count.
- Reset values: state IDLE, count 0, step 0, play_valid 0, play_dir 0, hit/round_pass/round_fail 0, timed_out 0, all timers 0.
- Playback:
  - play_valid rises on the first cycle after start is sampled.
  - Each symbol occupies exactly PLAY_ON_CYC + PLAY_GAP_CYC cycles.
  - CHECK is entered on the cycle after the last gap ends.
- Input response: hit, round_pass or round_fail is asserted the cycle after the in_valid edge, for exactly one cycle. busy is low in that same cycle on pass or fail.
- Timeout: round_fail is asserted TIMEOUT_CYC cycles after CHECK entry or after the last accepted in_valid.
- Full: at count==MAX_LEN, push_ready=0 and push is dropped. count never wraps.
- Reset asserted mid-playback or mid-check returns to reset values immediately (asynchronously) with no pulse.

## Test plan
- Config: DIR_W=2, MAX_LEN=4, PLAY_ON_CYC=3, PLAY_GAP_CYC=2, TIMEOUT_CYC=10.
- Push 2,0,3, then start -> play_valid high for 3 cycles with dir 2, low for 2, then 0, then 3. CHECK is entered 15 cycles after start is sampled; count=3.
- In CHECK, inputs 2,0,3 -> hit, hit, then round_pass on the cycle after the third input; busy low; count still 3.
- In CHECK, inputs 2 then 1 -> hit, then round_fail with timed_out=0; state IDLE.
- In CHECK, input 2 then idle 10 cycles -> round_fail and timed_out=1 exactly 10 cycles after the input. The next start clears timed_out.
- Push 5 symbols -> fifth is dropped, count=4, push_ready low. clear then gives count=0. start with count=0 leaves busy low.
- abort during PLAY_ON, and resetn low during CHECK -> IDLE, play_valid 0, no pulses. After abort count is preserved; after reset count=0.
